// File: rtl/zl_program_runner.sv
// Small self-check program executor: loads a program and expected outputs, then runs
// one instruction per clock over a local memory and grades the OUT stream on completion.
module zl_program_runner #(
    parameter int WIDTH    = 12,
    parameter int NLOCAL   = 16,
    parameter int NPROG    = 32,
    parameter int NOUT     = 8,
    parameter int MAXSTEPS = 1024,
    localparam int LAW = $clog2(NLOCAL),
    localparam int PAW = $clog2(NPROG),
    localparam int OAW = $clog2(NOUT),
    localparam int IW  = 6 + LAW + 2 * WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [PAW-1:0]   prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic             exp_we,
    input  logic [OAW-1:0]   exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [OAW:0]     exp_count,
    input  logic             start,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             finished,
    output logic             success,
    output logic             timeout,
    output logic [31:0]      steps
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [PAW:0] IP_END   = (PAW + 1)'(NPROG);
    localparam logic [PAW:0] IP_ONE   = (PAW + 1)'(1);
    localparam logic [OAW:0] OUT_END  = (OAW + 1)'(NOUT);
    localparam logic [31:0]  STEP_END = 32'(MAXSTEPS);

    state_t state_q, state_d;

    logic [IW-1:0]    prog_mem  [NPROG];
    logic [WIDTH-1:0] exp_mem   [NOUT];
    logic [WIDTH-1:0] local_mem [NLOCAL];

    // ip is one bit wider than a slot address so falling off the end is visible
    logic [PAW:0]     ip_q, ip_d;
    logic [OAW:0]     outpos_q, outpos_d, count_q;
    logic             mismatch_q, mismatch_d;
    logic [31:0]      steps_q, steps_d;

    logic [IW-1:0]    instr;
    logic [3:0]       op;
    logic             ia, ib;
    logic [LAW-1:0]   dst;
    logic [WIDTH-1:0] fa, fb, opa, opb;

    logic             wr_en, emit, halt, fall, tmo, run_end, timeout_hit, exp_ok;
    logic [WIDTH-1:0] wr_val;

    assign instr = prog_mem[ip_q[PAW-1:0]];
    assign {op, ia, ib, dst, fa, fb} = instr;
    assign opa = ia ? fa : local_mem[fa[LAW-1:0]];
    assign opb = ib ? fb : local_mem[fb[LAW-1:0]];

    always_comb begin
        ip_d   = ip_q + IP_ONE;
        wr_en  = 1'b0;
        wr_val = '0;
        emit   = 1'b0;
        halt   = 1'b0;
        case (op)
            4'd1:  begin wr_en = 1'b1; wr_val = opa;                  end
            4'd2:  begin wr_en = 1'b1; wr_val = opa + opb;            end
            4'd3:  begin wr_en = 1'b1; wr_val = opa - opb;            end
            4'd4:  begin wr_en = 1'b1; wr_val = opa + WIDTH'(1);      end
            4'd5:  begin wr_en = 1'b1; wr_val = opa - WIDTH'(1);      end
            4'd6:  emit = 1'b1;
            4'd7:  ip_d = {1'b0, opb[PAW-1:0]};
            4'd8:  if (opa == '0) ip_d = {1'b0, opb[PAW-1:0]};
            4'd9:  if (opa != '0) ip_d = {1'b0, opb[PAW-1:0]};
            4'd10: halt = 1'b1;
            default: ;
        endcase

        steps_d     = steps_q + 32'd1;
        // outputs beyond the expected table are always a mismatch
        exp_ok      = (outpos_q < OUT_END) && (exp_mem[outpos_q[OAW-1:0]] == opa);
        mismatch_d  = mismatch_q | (emit & ~exp_ok);
        outpos_d    = outpos_q + {{OAW{1'b0}}, emit};
        fall        = ip_d >= IP_END;
        tmo         = steps_d == STEP_END;
        run_end     = halt | fall | tmo;
        timeout_hit = ~halt & ~fall & tmo;

        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start)   state_d = S_RUN;
            S_RUN:          if (run_end) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ip_q       <= '0;
            steps_q    <= '0;
            outpos_q   <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            success    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            if (state_q != S_RUN && start) begin
                ip_q       <= '0;
                steps_q    <= '0;
                outpos_q   <= '0;
                mismatch_q <= 1'b0;
                count_q    <= exp_count;
                success    <= 1'b0;
                timeout    <= 1'b0;
            end else if (state_q == S_RUN) begin
                ip_q       <= ip_d;
                steps_q    <= steps_d;
                outpos_q   <= outpos_d;
                mismatch_q <= mismatch_d;
                out_valid  <= emit;
                if (emit) out_data <= opa;
                // grade with this edge's updates so a final OUT is included
                if (run_end) begin
                    timeout <= timeout_hit;
                    success <= ~mismatch_d & ~timeout_hit & (outpos_d == count_q);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q != S_RUN && prog_we) prog_mem[prog_addr] <= prog_data;
        if (state_q != S_RUN && exp_we)  exp_mem[exp_addr]   <= exp_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NLOCAL; i++) local_mem[i] <= '0;
        end else if (state_q == S_RUN && wr_en) begin
            local_mem[dst] <= wr_val;
        end
    end

    assign busy     = state_q == S_RUN;
    assign finished = state_q == S_DONE;
    assign steps    = steps_q;

endmodule
